fft_modulus_reader: RTL and testbench
=====================================

# fft_modulus_reader

Drain side of the FFT modulus FIFO: waits until a full spectrum frame has accumulated, reads it out with the FIFO's 1-cycle read latency, and streams it downstream over a valid/ready interface. A 2-entry skid buffer absorbs backpressure. Each frame also yields its peak magnitude and bin index for the oscilloscope display and measurement logic.

## Interface
Parameters:
- DATA_W, 73, FIFO word width; passed through unchanged.
- DEPTH_W, 12, FIFO depth width; water level is DEPTH_W+1 bits.
- FRAME_LEN, 1024, words per frame, 1..2**DEPTH_W.
- MAG_W, 32, magnitude field width, `rd_data[MAG_W-1:0]` (unsigned).

Ports:
- clk  in  1  single system clock, all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- start  in  1  one-cycle pulse that arms one frame; ignored while busy=1.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  DATA_W  FIFO data, valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_water_level  in  DEPTH_W+1  FIFO occupancy.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high on the final beat of a frame.
- m_index  out  DEPTH_W  bin index of the current beat, 0..FRAME_LEN-1.
- busy  out  1  high from the start acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.
- peak_mag  out  MAG_W  largest magnitude in the last completed frame.
- peak_index  out  DEPTH_W  bin index of peak_mag.

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and the skid buffer is empty.
- FSM states:
  - IDLE: start=1 moves to WAIT and clears the running peak and bin counters.
  - WAIT: fifo_rd_water_level >= FRAME_LEN moves to STREAM. Otherwise WAIT holds indefinitely.
  - STREAM: issues reads until FRAME_LEN reads have been issued, then moves to DRAIN.
  - DRAIN: the last beat handshake (m_valid & m_ready & m_last) moves to IDLE and pulses frame_done in the next cycle.
- Read issue rule: fifo_rd_en = (state==STREAM) & (issued < FRAME_LEN) & ~fifo_rd_empty & ((occ + inflight - pop) < 2).
  - occ is the skid buffer occupancy, 0..2.
  - inflight is fifo_rd_en registered.
  - pop = m_valid & m_ready.
  - This rule never reads while empty, and it sustains 1 beat/cycle when m_ready is held at 1.
- Skid buffer: 2-entry FIFO. The head entry drives m_data, m_index and m_last. m_valid = (occ != 0). On each push, the bin counter is attached to the entry.
- Peak tracking: on every accepted beat, if mag > running_peak, update the running peak and its index. The comparison is strict, so the earliest bin wins a tie. peak_mag and peak_index load from the running values at frame_done and hold until the next frame completes.
- The bin counter is DEPTH_W bits. m_last = (index == FRAME_LEN-1). The counter cannot wrap inside a frame.
- Simultaneous events:
  - A push and a pop in the same cycle leave occ unchanged.
  - start arriving in the same cycle as frame_done is ignored, because busy is still 1.
- Empty mid-frame (upstream drained externally): reads pause, the stream stalls, and the frame resumes when data returns. No data is dropped or duplicated.
- Reset during STREAM or DRAIN: the frame is abandoned, in-flight data is discarded, and no frame_done pulse is produced.

## Timing
- start at edge k gives WAIT in k+1. If the level is already sufficient, state is STREAM in k+2 and the first fifo_rd_en is high in that cycle. The first m_valid follows 2 cycles after that first read.
- Data latency: fifo_rd_en in cycle t, word captured at the end of t+1, m_valid in t+2.
- With m_ready=1 throughout, FRAME_LEN beats arrive on consecutive cycles. frame_done comes 1 cycle after the m_last handshake.
- m_data, m_index and m_last stay stable while m_valid=1 and m_ready=0.

## Structure
- Shared package fft_pkg holds:
  - the FIFO word width, depth width and frame length constants;
  - the magnitude field slice;
  - the state enum (IDLE, WAIT, STREAM, DRAIN).
- One natural sub-module, fft_skid_buf2: a 2-entry skid buffer with push/pop, occupancy output, and a {DATA_W+DEPTH_W+1}-bit payload.

## Test plan
- Frame of 1024 words with magnitudes 1023..0, m_ready=1 → 1024 consecutive beats with m_index 0..1023; m_last only on 1023; peak_mag=1023, peak_index=0; frame_done 1 cycle after the last beat.
- m_ready toggled 1,0,0,1 pseudo-randomly → no lost or duplicated words, output stable during stalls, and fifo_rd_en never asserted when occ+inflight would exceed 2.
- Water level at 1000 when start arrives → FSM holds in WAIT with fifo_rd_en=0; streaming begins 1 cycle after the level reaches 1024.
- Magnitude 500 at bins 10 and 700, all others <500 → peak_mag=500, peak_index=10.
- fifo_rd_empty forced to 1 for 5 cycles mid-frame → no read while empty, stream resumes, 1024 beats total in order.
- rst_n pulled low mid-STREAM, then start again → all outputs 0 during reset; the next frame starts at index 0 and reports correct peak values.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT modulus drain path.
package fft_pkg;

  // FIFO word layout and frame geometry
  localparam int FFT_DATA_W    = 73;
  localparam int FFT_DEPTH_W   = 12;
  localparam int FFT_FRAME_LEN = 1024;

  // Magnitude field: unsigned, sits in the low bits of each FIFO word
  localparam int FFT_MAG_W   = 32;
  localparam int FFT_MAG_LSB = 0;

  // Reader FSM encoding
  typedef logic [1:0] fft_state_t;
  localparam fft_state_t ST_IDLE   = 2'd0;
  localparam fft_state_t ST_WAIT   = 2'd1;
  localparam fft_state_t ST_STREAM = 2'd2;
  localparam fft_state_t ST_DRAIN  = 2'd3;

endpackage

// File: rtl/fft_skid_buf2.sv
// Two-entry skid buffer. Entries are written round-robin and the head entry
// is always presented on pop_data; occ reports how many entries are held.
module fft_skid_buf2
  import fft_pkg::*;
#(
  parameter int PAY_W = FFT_DATA_W + FFT_DEPTH_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PAY_W-1:0] push_data,
  input  logic             pop,
  output logic [PAY_W-1:0] pop_data,
  output logic [1:0]       occ
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] occ_reg;

  // One storage register per entry; cleared so the outputs read zero after reset
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [PAY_W-1:0] data_reg;

      // Capture the pushed payload when the write pointer selects this entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end
    end
  endgenerate

  assign pop_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
  assign occ      = occ_reg;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keep occ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/fft_modulus_reader.sv
// Drain side of the FFT modulus FIFO: waits for a full frame, reads it out
// with a 1-cycle read latency into a 2-entry skid buffer, streams it on a
// valid/ready port and reports the frame's peak magnitude and its bin.
module fft_modulus_reader
  import fft_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int DEPTH_W   = FFT_DEPTH_W,
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int MAG_W     = FFT_MAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               fifo_rd_en,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  input  logic               fifo_rd_empty,
  input  logic [DEPTH_W:0]   fifo_rd_water_level,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [DEPTH_W-1:0] m_index,
  output logic               busy,
  output logic               frame_done,
  output logic [MAG_W-1:0]   peak_mag,
  output logic [DEPTH_W-1:0] peak_index
);

  localparam int PAY_W = DATA_W + DEPTH_W + 1;
  localparam logic [DEPTH_W:0]   FRAME_LEN_C = (DEPTH_W + 1)'(FRAME_LEN);
  localparam logic [DEPTH_W:0]   LAST_ISSUE  = (DEPTH_W + 1)'(FRAME_LEN - 1);
  localparam logic [DEPTH_W-1:0] LAST_IDX    = DEPTH_W'(FRAME_LEN - 1);
  localparam logic [DEPTH_W:0]   ISSUE_ONE   = (DEPTH_W + 1)'(1);
  localparam logic [DEPTH_W-1:0] BIN_ONE     = DEPTH_W'(1);

  fft_state_t         state_reg;
  fft_state_t         state_next;
  logic [DEPTH_W:0]   issued_reg;
  logic               inflight_reg;
  logic [DEPTH_W-1:0] bin_reg;
  logic [MAG_W-1:0]   run_peak_reg;
  logic [MAG_W-1:0]   run_peak_next;
  logic [DEPTH_W-1:0] run_idx_reg;
  logic [DEPTH_W-1:0] run_idx_next;
  logic [MAG_W-1:0]   peak_mag_reg;
  logic [DEPTH_W-1:0] peak_idx_reg;
  logic               frame_done_reg;

  logic               start_accept;
  logic               push;
  logic               pop;
  logic               last_pop;
  logic               rd_en;
  logic [1:0]         occ;
  logic [2:0]         pending;
  logic [2:0]         limit;
  logic [PAY_W-1:0]   push_payload;
  logic [PAY_W-1:0]   head_payload;
  logic [MAG_W-1:0]   beat_mag;

  // busy stays up through the frame_done cycle so a coincident start is ignored
  assign busy         = (state_reg != ST_IDLE) | frame_done_reg;
  assign start_accept = start & ~busy;

  // Read data arrives the cycle after the strobe, so the registered strobe is the push
  assign push     = inflight_reg;
  assign pop      = m_valid & m_ready;
  assign last_pop = pop & m_last;

  // Words already committed to the buffer (stored + in flight) must leave room
  // for the one this read would add; a pop this cycle frees one slot.
  assign pending = {1'b0, occ} + {2'b00, inflight_reg};
  assign limit   = 3'd2 + {2'b00, pop};
  assign rd_en   = (state_reg == ST_STREAM) & (issued_reg < FRAME_LEN_C) &
                   ~fifo_rd_empty & (pending < limit);
  assign fifo_rd_en = rd_en;

  // The bin counter tags each word as it enters the buffer; m_last rides along
  assign push_payload = {(bin_reg == LAST_IDX), bin_reg, fifo_rd_data};

  fft_skid_buf2 #(
    .PAY_W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_payload),
    .pop      (pop),
    .pop_data (head_payload),
    .occ      (occ)
  );

  assign m_valid  = (occ != 2'd0);
  assign m_data   = head_payload[DATA_W-1:0];
  assign m_index  = head_payload[DATA_W +: DEPTH_W];
  assign m_last   = head_payload[PAY_W-1];
  assign beat_mag = m_data[FFT_MAG_LSB +: MAG_W];

  assign frame_done = frame_done_reg;
  assign peak_mag   = peak_mag_reg;
  assign peak_index = peak_idx_reg;

  // Running peak including the beat accepted this cycle; strict compare keeps the earliest bin
  always_comb begin
    run_peak_next = run_peak_reg;
    run_idx_next  = run_idx_reg;
    if (pop && (beat_mag > run_peak_reg)) begin
      run_peak_next = beat_mag;
      run_idx_next  = m_index;
    end
  end

  // Frame sequencing: arm, wait for a full frame, issue reads, drain the tail
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start_accept) state_next = ST_WAIT;
      ST_WAIT:   if (fifo_rd_water_level >= FRAME_LEN_C) state_next = ST_STREAM;
      ST_STREAM: if (rd_en && (issued_reg == LAST_ISSUE)) state_next = ST_DRAIN;
      ST_DRAIN:  if (last_pop) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, read-issue counter, in-flight flag and bin counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      issued_reg   <= '0;
      inflight_reg <= 1'b0;
      bin_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= rd_en;
      if (start_accept) begin
        issued_reg <= '0;
        bin_reg    <= '0;
      end else begin
        if (rd_en) begin
          issued_reg <= issued_reg + ISSUE_ONE;
        end
        if (push) begin
          bin_reg <= bin_reg + BIN_ONE;
        end
      end
    end
  end

  // Peak tracking, frame_done pulse and the per-frame peak report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_peak_reg   <= '0;
      run_idx_reg    <= '0;
      peak_mag_reg   <= '0;
      peak_idx_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= (state_reg == ST_DRAIN) & last_pop;
      if (start_accept) begin
        run_peak_reg <= '0;
        run_idx_reg  <= '0;
      end else begin
        run_peak_reg <= run_peak_next;
        run_idx_reg  <= run_idx_next;
      end
      // Publish the finished frame so the report is ready alongside frame_done
      if ((state_reg == ST_DRAIN) && last_pop) begin
        peak_mag_reg <= run_peak_next;
        peak_idx_reg <= run_idx_next;
      end
    end
  end

endmodule

// File: tb/tb_fft_modulus_reader.sv
// Scoreboard bench for fft_modulus_reader: a queue-based FIFO model feeds the
// DUT, expected beats and peaks are queued when a frame is armed, and a
// monitor pops and compares on every handshake and frame_done pulse.
module tb_fft_modulus_reader;
  import fft_pkg::*;

  localparam int DW = FFT_DATA_W;
  localparam int AW = FFT_DEPTH_W;
  localparam int FL = FFT_FRAME_LEN;
  localparam int MW = FFT_MAG_W;

  typedef logic [DW-1:0] word_t;
  typedef struct packed {
    word_t         data;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;
  typedef struct packed {
    logic [MW-1:0] mag;
    logic [AW-1:0] idx;
  } peak_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          fifo_rd_en;
  word_t         fifo_rd_data;
  logic          fifo_rd_empty;
  logic [AW:0]   fifo_rd_water_level;
  word_t         m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [AW-1:0] m_index;
  logic          busy;
  logic          frame_done;
  logic [MW-1:0] peak_mag;
  logic [AW-1:0] peak_index;

  fft_modulus_reader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_last             (m_last),
    .m_index            (m_index),
    .busy               (busy),
    .frame_done         (frame_done),
    .peak_mag           (peak_mag),
    .peak_index         (peak_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    failed = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    beat_cnt = 0;
  int    first_cyc = 0;
  int    last_cyc = 0;
  int    outstanding = 0;
  logic  rand_ready = 1'b0;
  logic  force_empty = 1'b0;
  word_t fifo_q[$];
  beat_t exp_q[$];
  peak_t exp_peak[$];
  word_t frame_w[FL];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle counter, advanced on the active edge and read on the falling edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: a read seen at cycle t returns its word during cycle t+1
  initial begin
    logic rd_pend;
    fifo_rd_data        = '0;
    fifo_rd_empty       = 1'b1;
    fifo_rd_water_level = '0;
    forever begin
      @(negedge clk);
      rd_pend = fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd_pend && (fifo_q.size() > 0)) fifo_rd_data = fifo_q.pop_front();
      #1;
      fifo_rd_empty       = force_empty || (fifo_q.size() == 0);
      fifo_rd_water_level = (AW + 1)'(fifo_q.size());
    end
  end

  // Downstream ready: held high or randomly toggled
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: read-issue rules, stall stability, beat and peak scoreboard
  initial begin
    logic  hold_valid;
    beat_t hold_beat;
    beat_t e;
    peak_t p;
    logic  pop;
    hold_valid = 1'b0;
    hold_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        hold_valid  = 1'b0;
      end else begin
        pop = m_valid && m_ready;
        if (fifo_rd_en) begin
          chk("rd_while_empty", 128'(fifo_rd_empty), 128'(0));
          chk("rd_overcommit", 128'((outstanding + 1 - (pop ? 1 : 0)) <= 2), 128'(1));
        end
        if (hold_valid) begin
          chk("stall_stable", 128'({m_valid, m_data, m_index, m_last}), 128'({1'b1, hold_beat}));
        end
        hold_valid = m_valid && !m_ready;
        if (hold_valid) hold_beat = {m_data, m_index, m_last};
        if (pop) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_beat: got index %0d, expected no beat", m_index);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 128'({m_data, m_index, m_last}), 128'(e));
          end
          if (m_index == '0) first_cyc = cyc;
          if (m_last) last_cyc = cyc;
        end
        outstanding = outstanding + (fifo_rd_en ? 1 : 0) - (pop ? 1 : 0);
        if (frame_done) begin
          done_cnt++;
          if (exp_peak.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
          end else begin
            p = exp_peak.pop_front();
            chk("peak", 128'({peak_mag, peak_index}), 128'(p));
            chk("done_latency", 128'(cyc), 128'(last_cyc + 1));
          end
          $display("[TB] frame %0d done: peak_mag=%0d peak_index=%0d beats=%0d",
                   done_cnt, peak_mag, peak_index, beat_cnt);
        end
      end
    end
  end

  // Frame content: 0 = descending 1023..0, 1 = random, 2 = 500 at bins 10 and 700, rest < 500
  task automatic build_frame(input int mode);
    word_t         w;
    logic [MW-1:0] mag;
    for (int i = 0; i < FL; i++) begin
      w = DW'({$urandom(), $urandom(), $urandom()});
      case (mode)
        0:       mag = MW'(FL - 1 - i);
        2:       mag = ((i == 10) || (i == 700)) ? MW'(500) : MW'($urandom_range(0, 499));
        default: mag = MW'($urandom());
      endcase
      w[MW-1:0]  = mag;
      frame_w[i] = w;
    end
  endtask

  // Reference: beats come out in FIFO order indexed 0..FL-1; the peak is the
  // first occurrence of the maximum magnitude (zero-magnitude frames report 0/0).
  task automatic arm_expect();
    beat_t         b;
    logic [MW-1:0] best;
    int            bi;
    best = '0;
    bi   = 0;
    for (int i = 0; i < FL; i++) begin
      b.data = frame_w[i];
      b.idx  = AW'(i);
      b.last = (i == FL - 1);
      exp_q.push_back(b);
      if (frame_w[i][MW-1:0] > best) begin
        best = frame_w[i][MW-1:0];
        bi   = i;
      end
    end
    exp_peak.push_back({best, AW'(bi)});
    beat_cnt = 0;
  endtask

  task automatic load_words(input int lo, input int hi);
    @(posedge clk);
    #1;
    for (int i = lo; i < hi; i++) fifo_q.push_back(frame_w[i]);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while ((done_cnt == d0) && (n < 20000)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 128'(done_cnt != d0), 128'(1));
    @(negedge clk);
    chk({name, "_idle"}, 128'(busy), 128'(0));
    chk({name, "_drained"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while ((beat_cnt < n) && (k < 10000)) begin
      @(negedge clk);
      k++;
    end
    chk("reach_beats", 128'(beat_cnt >= n), 128'(1));
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctl"}, 128'({fifo_rd_en, m_valid, m_last, m_index, busy, frame_done, peak_index}), 128'(0));
    chk({name, "_data"}, 128'({m_data, peak_mag}), 128'(0));
  endtask

  initial begin
    int rd_cyc;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Descending magnitudes, ready held high: start-to-read timing and back-to-back beats
    build_frame(0);
    arm_expect();
    load_words(0, FL);
    pulse_start();
    @(negedge clk);
    chk("wait_state", 128'({fifo_rd_en, busy}), 128'({1'b0, 1'b1}));
    @(negedge clk);
    chk("first_read", 128'(fifo_rd_en), 128'(1));
    rd_cyc = cyc;
    wait_done("desc");
    chk("first_beat_latency", 128'(first_cyc), 128'(rd_cyc + 2));
    chk("consecutive_beats", 128'(last_cyc - first_cyc), 128'(FL - 1));
    chk("desc_peak", 128'({peak_mag, peak_index}), 128'({MW'(1023), AW'(0)}));

    // Random data with random backpressure
    rand_ready = 1'b1;
    build_frame(1);
    arm_expect();
    load_words(0, FL);
    pulse_start();
    wait_done("stall");
    rand_ready = 1'b0;

    // Level short of a frame: hold in WAIT, stream one cycle after the level is reached
    build_frame(1);
    arm_expect();
    load_words(0, 1000);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("wait_hold", 128'(fifo_rd_en), 128'(0));
    end
    load_words(1000, FL);
    @(negedge clk);
    chk("wait_level_edge", 128'(fifo_rd_en), 128'(0));
    @(negedge clk);
    chk("stream_begin", 128'(fifo_rd_en), 128'(1));
    wait_done("level");

    // Tied maximum: earliest bin wins
    build_frame(2);
    arm_expect();
    load_words(0, FL);
    pulse_start();
    wait_done("tie");
    chk("tie_peak", 128'({peak_mag, peak_index}), 128'({MW'(500), AW'(10)}));

    // Empty flag forced mid-frame
    build_frame(1);
    arm_expect();
    load_words(0, FL);
    pulse_start();
    wait_beats(300);
    @(posedge clk);
    #1 force_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_no_read", 128'(fifo_rd_en), 128'(0));
    end
    @(posedge clk);
    #1 force_empty = 1'b0;
    wait_done("empty");
    chk("empty_beat_count", 128'(beat_cnt), 128'(FL));

    // Reset mid-stream abandons the frame; the next one starts clean
    build_frame(1);
    arm_expect();
    load_words(0, FL);
    pulse_start();
    wait_beats(200);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("mid_reset");
    exp_q.delete();
    exp_peak.delete();
    repeat (3) @(posedge clk);
    fifo_q.delete();
    @(negedge clk);
    chk_outputs_zero("held_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    rand_ready = 1'b1;
    build_frame(1);
    arm_expect();
    load_words(0, FL);
    pulse_start();
    wait_done("after_reset");
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Backstop in case a bounded wait is ever bypassed
  initial begin
    #800000;
    $display("FAIL watchdog: got no completion by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
